// File: rtl/shot_timer_ctrl_pkg.sv
// Shared game definitions for the shot timer and the fire-ready bar decoder.
package shot_timer_ctrl_pkg;

    // Shot controller state encoding.
    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RECHARGE = 2'd1,
        ST_READY    = 2'd2
    } shot_state_t;

    // shot_timer levels shared with shot_timer_to_frb.
    localparam logic [1:0] SHOT_EMPTY = 2'd3;
    localparam logic [1:0] SHOT_FULL  = 2'd0;

    // One recharge step. The result saturates at SHOT_FULL and never wraps.
    function automatic logic [1:0] shot_step_down(input logic [1:0] level);
        if (level == SHOT_FULL) begin
            return SHOT_FULL;
        end else begin
            return level - 2'd1;
        end
    endfunction

endpackage

// File: rtl/shot_timer_ctrl_edge_detect_rise.sv
// Rising-edge detector for an already-synchronised button level.
// The delayed copy resets to RESET_VAL. With the default of 1, a button held
// through reset does not report an edge.
module edge_detect_rise #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_d_r;

    // Keep a one-cycle delayed copy of the input level.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_d_r <= RESET_VAL;
        end else begin
            din_d_r <= din;
        end
    end

    assign rise = din & ~din_d_r;

endmodule

// File: rtl/shot_timer_ctrl.sv
// Shot timer controller. It turns a trigger rising edge into a one-cycle fire
// pulse, then recharges shot_timer 3->2->1->0, taking one step per
// TICKS_PER_STEP frame ticks.
module shot_timer_ctrl
    import shot_timer_ctrl_pkg::*;
#(
    parameter int TICKS_PER_STEP = 15,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       trigger,
    input  logic       enable,
    output logic [1:0] shot_timer,
    output logic       fire_pulse,
    output logic       ready
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [CNT_W-1:0] TICK_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);

    shot_state_t      state_r;
    shot_state_t      state_s;
    logic [1:0]       shot_timer_r;
    logic [1:0]       shot_timer_s;
    logic [CNT_W-1:0] tick_cnt_r;
    logic [CNT_W-1:0] tick_cnt_s;
    logic             fire_pulse_r;
    logic             fire_pulse_s;
    logic             ready_r;
    logic             ready_s;
    logic             press_s;

    edge_detect_rise #(
        .RESET_VAL (1'b1)
    ) u_trigger_edge (
        .clk   (clk),
        .reset (reset),
        .din   (trigger),
        .rise  (press_s)
    );

    // Next-state and next-output logic. enable low overrides every other input.
    always_comb begin
        state_s      = state_r;
        shot_timer_s = shot_timer_r;
        tick_cnt_s   = tick_cnt_r;
        fire_pulse_s = 1'b0;

        if (!enable) begin
            state_s      = ST_DISABLED;
            shot_timer_s = SHOT_EMPTY;
            tick_cnt_s   = TICK_ZERO;
        end else begin
            case (state_r)
                ST_DISABLED: begin
                    state_s      = ST_RECHARGE;
                    shot_timer_s = SHOT_EMPTY;
                    tick_cnt_s   = TICK_ZERO;
                end
                ST_RECHARGE: begin
                    // A press here is dropped; only frame ticks advance the recharge.
                    if (frame_tick) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_s   = TICK_ZERO;
                            shot_timer_s = shot_step_down(shot_timer_r);
                            if (shot_timer_s == SHOT_FULL) begin
                                state_s = ST_READY;
                            end else begin
                                state_s = ST_RECHARGE;
                            end
                        end else begin
                            tick_cnt_s = tick_cnt_r + TICK_ONE;
                        end
                    end else begin
                        state_s = ST_RECHARGE;
                    end
                end
                ST_READY: begin
                    shot_timer_s = SHOT_FULL;
                    // A shot takes priority over a frame tick in the same cycle.
                    if (press_s) begin
                        state_s      = ST_RECHARGE;
                        shot_timer_s = SHOT_EMPTY;
                        tick_cnt_s   = TICK_ZERO;
                        fire_pulse_s = 1'b1;
                    end else begin
                        state_s = ST_READY;
                    end
                end
                default: begin
                    state_s      = ST_DISABLED;
                    shot_timer_s = SHOT_EMPTY;
                    tick_cnt_s   = TICK_ZERO;
                end
            endcase
        end

        ready_s = (state_s == ST_READY);
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_DISABLED;
            shot_timer_r <= SHOT_EMPTY;
            tick_cnt_r   <= TICK_ZERO;
            fire_pulse_r <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            shot_timer_r <= shot_timer_s;
            tick_cnt_r   <= tick_cnt_s;
            fire_pulse_r <= fire_pulse_s;
            ready_r      <= ready_s;
        end
    end

    assign shot_timer = shot_timer_r;
    assign fire_pulse = fire_pulse_r;
    assign ready      = ready_r;

endmodule

// File: tb/tb_shot_timer_ctrl.sv
// Self-checking bench for shot_timer_ctrl with TICKS_PER_STEP = 4.
module tb_shot_timer_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       trigger;
    logic       enable;
    logic [1:0] shot_timer;
    logic       fire_pulse;
    logic       ready;

    int checks;
    int failures;
    int fire_cnt;

    typedef struct {
        logic       r;
        logic       e;
        logic       t;
        logic       k;
        logic [1:0] es;
        logic       ef;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    shot_timer_ctrl #(
        .TICKS_PER_STEP (4),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .trigger    (trigger),
        .enable     (enable),
        .shot_timer (shot_timer),
        .fire_pulse (fire_pulse),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic t, input logic k);
        @(negedge clk);
        reset      = r;
        enable     = e;
        trigger    = t;
        frame_tick = k;
        @(posedge clk);
        #1;
        if (fire_pulse === 1'b1) fire_cnt++;
    endtask

    task automatic chk(input string name, input logic [1:0] es, input logic ef, input logic er);
        checks++;
        if (shot_timer !== es || fire_pulse !== ef || ready !== er) begin
            failures++;
            $display("FAIL %s: got shot=%0d fire=%0b ready=%0b, expected shot=%0d fire=%0b ready=%0b",
                     name, shot_timer, fire_pulse, ready, es, ef, er);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic t, input logic k,
                       input logic [1:0] es, input logic ef, input logic er);
        vec_t v;
        v.r = r; v.e = e; v.t = t; v.k = k; v.es = es; v.ef = ef; v.er = er;
        vecs.push_back(v);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        fire_cnt   = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        trigger    = 1'b0;
        frame_tick = 1'b0;

        // Reset, charge with 12 ticks, then fire once.
        //  r     e     t     k     shot  fire  ready
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].e, vecs[i].t, vecs[i].k);
            chk($sformatf("vec%0d", i), vecs[i].es, vecs[i].ef, vecs[i].er);
        end

        // Trigger stays held: 19 more ticks (20 since the shot) must not re-fire.
        fire_cnt = 0;
        for (int i = 0; i < 19; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk_int("held_no_refire", fire_cnt, 0);
        chk("held_ready", 2'd0, 1'b0, 1'b1);

        // Press and frame tick in the same READY cycle.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("press_tick_fire", 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("press_tick_3", 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("press_tick_4", 2'd2, 1'b0, 1'b0);

        // Press during recharge at shot_timer = 2 is discarded.
        fire_cnt = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("recharge_press", 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("recharge_tick11", 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("recharge_tick12", 2'd0, 1'b0, 1'b1);
        chk_int("recharge_no_fire", fire_cnt, 0);

        // Fire, recharge to shot_timer = 1, then drop enable with a press.
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("fire_again", 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("at_one", 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("disable_press", 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("reenable_11", 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("reenable_12", 2'd0, 1'b0, 1'b1);

        // Dropping enable in READY with a press does not fire.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("disable_in_ready", 2'd3, 1'b0, 1'b0);

        // Trigger held through reset release cannot fire until pressed again.
        fire_cnt = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("reset_held", 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("held_reset_ready", 2'd0, 1'b0, 1'b1);
        chk_int("held_reset_no_fire", fire_cnt, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("repress_fire", 2'd3, 1'b1, 1'b0);

        // Reset in mid-recharge, then verify the tick counter restarts from 0.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("mid_recharge", 2'd2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("mid_reset", 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("post_reset_3", 2'd3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("post_reset_4", 2'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
